// File: rtl/axi_lite_rd_arbiter_if.sv
// rtl/axi_lite_rd_arbiter_if.sv - shared AXI-lite read bus between requesting masters and one slave
interface axi_lite_rd_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
    logic [NUM_MASTERS-1:0]        m_arvalid;
    logic [NUM_MASTERS-1:0]        m_arready;
    logic [DATA_W-1:0]             m_rdata;
    logic [1:0]                    m_rresp;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic [NUM_MASTERS-1:0]        m_rready;
    logic [ADDR_W-1:0]             s_araddr;
    logic                          s_arvalid;
    logic                          s_arready;
    logic [DATA_W-1:0]             s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rvalid;
    logic                          s_rready;

    // Arbiter view: accepts requests from the masters, issues them to the slave.
    modport slave (
        input  m_araddr, m_arvalid, m_rready,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        output s_araddr, s_arvalid, s_rready
    );

    // Environment view: requesting masters plus the memory/peripheral model.
    modport master (
        output m_araddr, m_arvalid, m_rready,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        input  s_araddr, s_arvalid, s_rready
    );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// rtl/axi_lite_rd_arbiter.sv - round-robin AXI-lite read arbiter, one outstanding transaction
module axi_lite_rd_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_rd_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [ADDR_W-1:0]  araddr_q;
    logic               arvalid_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_addr;

    // Scan starts just after the previous winner so each requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int cand;
            cand = (int'(last_grant) + k) % NUM_MASTERS;
            if (!win_found && bus.m_arvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_addr = bus.m_araddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        bus.m_arready = '0;
        bus.m_rvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_arready[i] = (state == IDLE) && win_found && (win_idx == IDX_W'(i));
            bus.m_rvalid[i]  = (state == RESP) && bus.s_rvalid && (grant_idx == IDX_W'(i));
        end
    end

    logic granted_rready;
    always_comb begin
        granted_rready = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                granted_rready = bus.m_rready[i];
            end
        end
    end

    assign bus.s_rready  = (state == RESP) && granted_rready;
    assign bus.m_rdata   = bus.s_rdata;
    assign bus.m_rresp   = bus.s_rresp;
    assign bus.s_araddr  = araddr_q;
    assign bus.s_arvalid = arvalid_q;

    // Address stays in araddr_q through RESP since the slave may sample it late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        araddr_q  <= win_addr;
                        grant_idx <= win_idx;
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (arvalid_q && bus.s_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.s_rvalid && granted_rready) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb/tb_axi_lite_rd_arbiter.sv - directed self-checking bench for axi_lite_rd_arbiter
module tb_axi_lite_rd_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    axi_lite_rd_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_rd_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_araddr  = '0;
        bus.m_arvalid = '0;
        bus.m_rready  = '0;
        bus.s_arready = 1'b0;
        bus.s_rdata   = '0;
        bus.s_rresp   = '0;
        bus.s_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #12;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // Full transaction starting in IDLE with m_arvalid already driven by the caller.
    task automatic txn(input string nm, input logic [1:0] gmask, input logic [31:0] addr,
                       input int ar_stall, input int r_stall,
                       input logic [31:0] rdata, input logic [1:0] rresp);
        #1;
        check({nm, ".arready"}, 64'(bus.m_arready), 64'(gmask));
        bus.s_arready = 1'b0;
        step();
        bus.m_arvalid = bus.m_arvalid & ~gmask;
        check({nm, ".s_arvalid"}, 64'(bus.s_arvalid), 64'd1);
        check({nm, ".s_araddr"}, 64'(bus.s_araddr), 64'(addr));
        for (int i = 0; i < ar_stall; i++) begin
            step();
            check({nm, ".stall_arvalid"}, 64'(bus.s_arvalid), 64'd1);
            check({nm, ".stall_araddr"}, 64'(bus.s_araddr), 64'(addr));
            check({nm, ".stall_arready"}, 64'(bus.m_arready), 64'd0);
        end
        bus.s_arready = 1'b1;
        step();
        bus.s_arready = 1'b0;
        check({nm, ".resp_arvalid"}, 64'(bus.s_arvalid), 64'd0);
        check({nm, ".resp_araddr"}, 64'(bus.s_araddr), 64'(addr));
        bus.s_rvalid = 1'b1;
        bus.s_rdata  = rdata;
        bus.s_rresp  = rresp;
        bus.m_rready = ~gmask;
        for (int i = 0; i < r_stall; i++) begin
            #1;
            check({nm, ".bp_rvalid"}, 64'(bus.m_rvalid), 64'(gmask));
            check({nm, ".bp_rready"}, 64'(bus.s_rready), 64'd0);
            check({nm, ".bp_araddr"}, 64'(bus.s_araddr), 64'(addr));
            step();
        end
        bus.m_rready = 2'b11;
        #1;
        check({nm, ".rvalid"}, 64'(bus.m_rvalid), 64'(gmask));
        check({nm, ".s_rready"}, 64'(bus.s_rready), 64'd1);
        check({nm, ".rdata"}, 64'(bus.m_rdata), 64'(rdata));
        check({nm, ".rresp"}, 64'(bus.m_rresp), 64'(rresp));
        step();
        bus.s_rvalid = 1'b0;
        bus.m_rready = 2'b00;
        #1;
        check({nm, ".idle_rvalid"}, 64'(bus.m_rvalid), 64'd0);
        check({nm, ".idle_rready"}, 64'(bus.s_rready), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        #2;
        check("reset.s_arvalid", 64'(bus.s_arvalid), 64'd0);
        check("reset.s_araddr", 64'(bus.s_araddr), 64'd0);
        check("reset.m_arready", 64'(bus.m_arready), 64'd0);
        check("reset.m_rvalid", 64'(bus.m_rvalid), 64'd0);
        check("reset.s_rready", 64'(bus.s_rready), 64'd0);
        do_reset();

        // Single request from master 1
        bus.m_araddr[63:32] = 32'h8000_0004;
        bus.m_arvalid       = 2'b10;
        txn("single", 2'b10, 32'h8000_0004, 0, 0, 32'h1234_5678, 2'b00);

        // Simultaneous requests from reset: strict alternation 0,1,0
        do_reset();
        bus.m_araddr  = {32'h8000_0100, 32'h8000_0000};
        bus.m_arvalid = 2'b11;
        txn("rr0", 2'b01, 32'h8000_0000, 0, 0, 32'hA000_0000, 2'b00);
        check("rr.m1_still_req", 64'(bus.m_arvalid), 64'd2);
        txn("rr1", 2'b10, 32'h8000_0100, 0, 0, 32'hA000_0100, 2'b00);
        bus.m_arvalid = 2'b11;
        txn("rr2", 2'b01, 32'h8000_0000, 0, 0, 32'hA000_0001, 2'b00);

        // Slave AR stall then master R backpressure, on master 1 (next in turn)
        txn("stall", 2'b10, 32'h8000_0100, 5, 4, 32'h5555_AAAA, 2'b00);

        // Error response forwarded unchanged
        bus.m_arvalid = 2'b01;
        txn("err", 2'b01, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 2'b10);

        // Reset asserted mid-RESP, between clock edges
        bus.m_arvalid = 2'b10;
        #1;
        check("rst.arready", 64'(bus.m_arready), 64'd2);
        step();
        bus.m_arvalid = 2'b00;
        bus.s_arready = 1'b1;
        step();
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b1;
        #1;
        check("rst.pre_rvalid", 64'(bus.m_rvalid), 64'd2);
        bus.m_rready = 2'b10;
        #1;
        check("rst.pre_rready", 64'(bus.s_rready), 64'd1);
        bus.m_rready = 2'b00;
        rst = 1'b1;
        #1;
        check("rst.async_arvalid", 64'(bus.s_arvalid), 64'd0);
        check("rst.async_rready", 64'(bus.s_rready), 64'd0);
        check("rst.async_rvalid", 64'(bus.m_rvalid), 64'd0);
        check("rst.async_araddr", 64'(bus.s_araddr), 64'd0);
        bus.s_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.m_arvalid = 2'b11;
        #1;
        check("rst.first_winner", 64'(bus.m_arready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
